// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
//   Captures operands A then B from a shared bus on LOAD rising edges, holds
//   them on the function-unit inputs, registers the unit's result one cycle
//   after B is captured, and counts completed operations.
//   All outputs come straight from registers, so there is no combinational
//   path from any input to any output.
module alu_operand_sequencer #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  input  logic             CLEAR,
  input  logic [WIDTH-1:0] Y_IN,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RESULT,
  output logic             RES_VALID,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] OP_CNT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             load_q;
  logic             ld_ev;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One event per LOAD rising edge; a held-high LOAD fires only once.
  assign ld_ev = LOAD & ~load_q;

  // State, edge-detect and datapath registers; reset wins over everything.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= LOAD;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath updates; CLEAR beats a load event in every state.
  // The counter survives CLEAR on purpose: only a hard reset zeroes it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    if (CLEAR) begin
      state_d = IDLE;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      vld_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ld_ev) begin
            a_d     = DIN;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (ld_ev) begin
            b_d     = DIN;
            state_d = EXEC;
          end
        end
        EXEC: begin
          // Y_IN is settled from the A/B registers; a load here is dropped.
          res_d   = Y_IN;
          vld_d   = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = DONE;
        end
        DONE: begin
          // Chain into the next operation: new A, B kept until replaced.
          if (ld_ev) begin
            a_d     = DIN;
            vld_d   = 1'b0;
            state_d = WAIT_B;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign RESULT    = res_q;
  assign RES_VALID = vld_q;
  assign STATE     = state_q;
  assign OP_CNT    = cnt_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer: an 8-bit-counter instance is checked by a
// result scoreboard and directed checks; a 2-bit-counter instance shares the
// same stimulus to exercise counter wrap.
module tb_alu_operand_sequencer;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [5:0] DIN;
  logic       LOAD;
  logic       CLEAR;

  logic [5:0] a, b, res, y;
  logic       vld;
  logic [1:0] st;
  logic [7:0] cnt;

  logic [5:0] w_a, w_b, w_res, w_y;
  logic       w_vld;
  logic [1:0] w_st;
  logic [1:0] w_cnt;

  assign y   = a ^ b;
  assign w_y = w_a ^ w_b;

  alu_operand_sequencer #(.WIDTH(6), .CNT_W(8)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .LOAD(LOAD), .CLEAR(CLEAR),
    .Y_IN(y), .A(a), .B(b), .RESULT(res), .RES_VALID(vld), .STATE(st),
    .OP_CNT(cnt)
  );

  alu_operand_sequencer #(.WIDTH(6), .CNT_W(2)) u_wrap (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .LOAD(LOAD), .CLEAR(CLEAR),
    .Y_IN(w_y), .A(w_a), .B(w_b), .RESULT(w_res), .RES_VALID(w_vld),
    .STATE(w_st), .OP_CNT(w_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0] res;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] m_cnt8 = 8'd0;
  logic [1:0] m_cnt2 = 2'd0;
  logic [5:0] m_a = 6'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every new RES_VALID rise must match the oldest expected op.
  logic vld_prev = 1'b0;
  always @(negedge CLK) begin
    if (vld && !vld_prev) begin
      if (sb.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
      else begin
        chk("sb_result", {26'd0, res}, {26'd0, sb[0].res});
        chk("sb_opcnt", {24'd0, cnt}, {24'd0, sb[0].cnt});
        void'(sb.pop_front());
      end
    end
    vld_prev <= vld;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_pulse(input logic [5:0] d);
    DIN  = d;
    LOAD = 1'b1;
    cyc();
    LOAD = 1'b0;
    cyc();
  endtask

  // A then B; expectation is queued as B is driven.
  task automatic do_op(input logic [5:0] da, input logic [5:0] db);
    load_pulse(da);
    m_a = da;
    m_cnt8 = m_cnt8 + 8'd1;
    m_cnt2 = m_cnt2 + 2'd1;
    sb.push_back('{res: da ^ db, cnt: m_cnt8});
    load_pulse(db);
    chk("op_result", {26'd0, res}, {26'd0, da ^ db});
    chk("op_valid", {31'd0, vld}, 32'd1);
    chk("op_state", {30'd0, st}, 32'd3);
    chk("wrap_result", {26'd0, w_res}, {26'd0, da ^ db});
    chk("wrap_cnt", {30'd0, w_cnt}, {30'd0, m_cnt2});
  endtask

  initial begin
    RST_N = 1'b0; DIN = '0; LOAD = 1'b0; CLEAR = 1'b0;
    #3;
    chk("rst_a", {26'd0, a}, 32'd0);
    chk("rst_state", {30'd0, st}, 32'd0);
    chk("rst_cnt", {24'd0, cnt}, 32'd0);
    cyc(); cyc();
    RST_N = 1'b1;
    cyc();

    // Async reset mid-WAIT_B, observed without a clock edge
    load_pulse(6'h2A);
    chk("waitb_state", {30'd0, st}, 32'd1);
    chk("waitb_a", {26'd0, a}, 32'h2A);
    RST_N = 1'b0;
    #1;
    chk("async_a", {26'd0, a}, 32'd0);
    chk("async_state", {30'd0, st}, 32'd0);
    chk("async_vld", {31'd0, vld}, 32'd0);
    cyc();
    RST_N = 1'b1;
    cyc();
    chk("post_rst_state", {30'd0, st}, 32'd0);

    // XOR pair with explicit latency check
    load_pulse(6'h2A);
    m_cnt8 = m_cnt8 + 8'd1;
    m_cnt2 = m_cnt2 + 2'd1;
    sb.push_back('{res: 6'h3F, cnt: m_cnt8});
    DIN = 6'h15; LOAD = 1'b1;
    cyc();
    chk("lat_b", {26'd0, b}, 32'h15);
    chk("lat_exec", {30'd0, st}, 32'd2);
    chk("lat_vld0", {31'd0, vld}, 32'd0);
    LOAD = 1'b0;
    cyc();
    chk("xor_result", {26'd0, res}, 32'h3F);
    chk("xor_vld", {31'd0, vld}, 32'd1);
    chk("xor_cnt", {24'd0, cnt}, 32'd1);

    // Back to IDLE via CLEAR; counter survives
    CLEAR = 1'b1;
    cyc();
    CLEAR = 1'b0;
    chk("clr_state", {30'd0, st}, 32'd0);
    chk("clr_result", {26'd0, res}, 32'd0);
    chk("clr_vld", {31'd0, vld}, 32'd0);
    chk("clr_cnt", {24'd0, cnt}, {24'd0, m_cnt8});

    // Held LOAD: one capture only
    DIN = 6'h11; LOAD = 1'b1;
    cyc();
    DIN = 6'h22;
    for (int i = 0; i < 9; i++) cyc();
    chk("hold_a", {26'd0, a}, 32'h11);
    chk("hold_b", {26'd0, b}, 32'd0);
    chk("hold_state", {30'd0, st}, 32'd1);
    LOAD = 1'b0;
    cyc();

    // Finish that op with B, then chain from DONE
    m_cnt8 = m_cnt8 + 8'd1;
    m_cnt2 = m_cnt2 + 2'd1;
    sb.push_back('{res: 6'h11 ^ 6'h0C, cnt: m_cnt8});
    load_pulse(6'h0C);
    chk("hold_op_result", {26'd0, res}, 32'h1D);
    load_pulse(6'h01);
    chk("chain_a", {26'd0, a}, 32'h01);
    chk("chain_b_kept", {26'd0, b}, 32'h0C);
    chk("chain_vld", {31'd0, vld}, 32'd0);
    chk("chain_state", {30'd0, st}, 32'd1);
    m_cnt8 = m_cnt8 + 8'd1;
    m_cnt2 = m_cnt2 + 2'd1;
    sb.push_back('{res: 6'h00, cnt: m_cnt8});
    load_pulse(6'h01);
    chk("chain_result", {26'd0, res}, 32'h00);
    chk("chain_cnt", {24'd0, cnt}, {24'd0, m_cnt8});

    // CLEAR and LOAD rising together in WAIT_B
    CLEAR = 1'b1; cyc(); CLEAR = 1'b0;
    load_pulse(6'h07);
    DIN = 6'h09; LOAD = 1'b1; CLEAR = 1'b1;
    cyc();
    CLEAR = 1'b0; LOAD = 1'b0;
    chk("cl_state", {30'd0, st}, 32'd0);
    chk("cl_a", {26'd0, a}, 32'd0);
    chk("cl_b", {26'd0, b}, 32'd0);
    chk("cl_cnt", {24'd0, cnt}, {24'd0, m_cnt8});
    cyc();

    // Random ops; the 2-bit instance wraps along the way
    for (int i = 0; i < 6; i++) begin
      do_op(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    end

    cyc();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
